tictactoe_game_ctrl: RTL and testbench

Sequential game controller for the tic-tac-toe design. It holds the registered X and O boards and accepts the human player's moves through a valid/ready handshake. It drives the boards into the combinational AI move selector and captures that block's one-hot O move. It also detects win, draw and fault conditions, and tracks turn order.

---
 rtl/tictactoe_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tictactoe_game_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_game_ctrl.sv
// tictactoe_game_ctrl: sequential controller for tic-tac-toe.
// Holds the X/O boards, takes player X moves over a valid/ready handshake,
// captures the one-hot O move from the combinational AI selector, and
// flags win/draw/AI-fault results.
// Optional macro TTT_SCORE_EN adds saturating 4-bit score counters.
module tictactoe_game_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic [8:0] xin,
  output logic [8:0] oin,
  input  logic [8:0] ai_move,
  output logic       illegal,
  output logic       x_win,
  output logic       o_win,
  output logic       draw,
  output logic       ai_fault,
`ifdef TTT_SCORE_EN
  output logic [3:0] x_score,
  output logic [3:0] o_score,
  output logic [3:0] draw_score,
`endif
  output logic       game_over
);

  typedef enum logic [2:0] {WAIT_X, CHECK_X, AI, CHECK_O, DONE} state_t;

  // Eight winning lines; bit (8 - cell) marks each cell.
  // Rows, columns, then the two diagonals.
  localparam logic [71:0] LINE_MASKS = {9'h1C0, 9'h038, 9'h007,
                                        9'h124, 9'h092, 9'h049,
                                        9'h111, 9'h054};

  state_t     state_reg, state_next;
  logic [8:0] xin_reg, xin_next;
  logic [8:0] oin_reg, oin_next;
  logic       illegal_reg, illegal_next;
  logic       x_win_reg, x_win_next;
  logic       o_win_reg, o_win_next;
  logic       draw_reg, draw_next;
  logic       ai_fault_reg, ai_fault_next;

  logic [7:0] x_line;
  logic [7:0] o_line;
  logic [8:0] occupied;
  logic [8:0] move_bit;
  logic       handshake;
  logic       ai_onehot;
  logic       ai_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign x_line[gi] = (xin_reg & LINE_MASKS[gi*9 +: 9]) == LINE_MASKS[gi*9 +: 9];
      assign o_line[gi] = (oin_reg & LINE_MASKS[gi*9 +: 9]) == LINE_MASKS[gi*9 +: 9];
    end
  endgenerate

  assign occupied   = xin_reg | oin_reg;
  // Cells beyond 8 shift out to zero; they are rejected by the range test anyway.
  assign move_bit   = 9'h100 >> move_pos;
  assign move_ready = (state_reg == WAIT_X);
  assign handshake  = move_valid & move_ready;
  assign ai_onehot  = (ai_move != 9'd0) && ((ai_move & (ai_move - 9'd1)) == 9'd0);
  assign ai_valid   = ai_onehot && ((ai_move & occupied) == 9'd0);

  // Next-state and next-board/flag logic; new_game overrides every state.
  always_comb begin
    state_next    = state_reg;
    xin_next      = xin_reg;
    oin_next      = oin_reg;
    illegal_next  = 1'b0;
    x_win_next    = x_win_reg;
    o_win_next    = o_win_reg;
    draw_next     = draw_reg;
    ai_fault_next = ai_fault_reg;
    if (new_game) begin
      state_next    = WAIT_X;
      xin_next      = 9'd0;
      oin_next      = 9'd0;
      x_win_next    = 1'b0;
      o_win_next    = 1'b0;
      draw_next     = 1'b0;
      ai_fault_next = 1'b0;
    end else begin
      case (state_reg)
        WAIT_X: begin
          if (handshake) begin
            if (move_pos > 4'd8 || (occupied & move_bit) != 9'd0) begin
              illegal_next = 1'b1;
            end else begin
              xin_next   = xin_reg | move_bit;
              state_next = CHECK_X;
            end
          end
        end
        CHECK_X: begin
          if (|x_line) begin
            x_win_next = 1'b1;
            state_next = DONE;
          end else if (occupied == 9'h1FF) begin
            draw_next  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = AI;
          end
        end
        AI: begin
          if (!ai_valid) begin
            ai_fault_next = 1'b1;
            state_next    = DONE;
          end else begin
            oin_next   = oin_reg | ai_move;
            state_next = CHECK_O;
          end
        end
        CHECK_O: begin
          if (|o_line) begin
            o_win_next = 1'b1;
            state_next = DONE;
          end else if (occupied == 9'h1FF) begin
            draw_next  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT_X;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = WAIT_X;
      endcase
    end
  end

  // State, board and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WAIT_X;
      xin_reg      <= 9'd0;
      oin_reg      <= 9'd0;
      illegal_reg  <= 1'b0;
      x_win_reg    <= 1'b0;
      o_win_reg    <= 1'b0;
      draw_reg     <= 1'b0;
      ai_fault_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      xin_reg      <= xin_next;
      oin_reg      <= oin_next;
      illegal_reg  <= illegal_next;
      x_win_reg    <= x_win_next;
      o_win_reg    <= o_win_next;
      draw_reg     <= draw_next;
      ai_fault_reg <= ai_fault_next;
    end
  end

  assign xin       = xin_reg;
  assign oin       = oin_reg;
  assign illegal   = illegal_reg;
  assign x_win     = x_win_reg;
  assign o_win     = o_win_reg;
  assign draw      = draw_reg;
  assign ai_fault  = ai_fault_reg;
  assign game_over = x_win_reg | o_win_reg | draw_reg | ai_fault_reg;

`ifdef TTT_SCORE_EN
  logic [3:0] x_score_reg, o_score_reg, draw_score_reg;

  // Score counters bump on a flag's rising edge, saturate at 15, survive new_game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_score_reg    <= 4'd0;
      o_score_reg    <= 4'd0;
      draw_score_reg <= 4'd0;
    end else begin
      if (x_win_next && !x_win_reg && x_score_reg != 4'hF)
        x_score_reg <= x_score_reg + 4'd1;
      if (o_win_next && !o_win_reg && o_score_reg != 4'hF)
        o_score_reg <= o_score_reg + 4'd1;
      if (draw_next && !draw_reg && draw_score_reg != 4'hF)
        draw_score_reg <= draw_score_reg + 4'd1;
    end
  end

  assign x_score    = x_score_reg;
  assign o_score    = o_score_reg;
  assign draw_score = draw_score_reg;
`endif

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// tb_tictactoe_game_ctrl: scoreboard bench for tictactoe_game_ctrl.
// Stimulus pushes expected outcomes; a negedge monitor pops one whenever the
// DUT presents a result (illegal pulse, move_ready returning, game_over rising).
module tb_tictactoe_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic [8:0] ai_move = 9'd0;
  logic       move_ready, illegal, x_win, o_win, draw, ai_fault, game_over;
  logic [8:0] xin, oin;
`ifdef TTT_SCORE_EN
  logic [3:0] x_score, o_score, draw_score;
`endif

  tictactoe_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .xin        (xin),
    .oin        (oin),
    .ai_move    (ai_move),
    .illegal    (illegal),
    .x_win      (x_win),
    .o_win      (o_win),
    .draw       (draw),
    .ai_fault   (ai_fault),
`ifdef TTT_SCORE_EN
    .x_score    (x_score),
    .o_score    (o_score),
    .draw_score (draw_score),
`endif
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Flag field order: {ready, illegal, x_win, o_win, draw, ai_fault, game_over}
  localparam logic [6:0] F_RDY  = 7'b1000000;
  localparam logic [6:0] F_ILL  = 7'b1100000;
  localparam logic [6:0] F_XW   = 7'b0010001;
  localparam logic [6:0] F_OW   = 7'b0001001;
  localparam logic [6:0] F_DR   = 7'b0000101;
  localparam logic [6:0] F_AF   = 7'b0000011;
  localparam logic [6:0] F_BUSY = 7'b0000000;

  typedef struct {
    int         cyc;
    logic [24:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          txn = 0;
  logic [24:0] act;

  assign act = {xin, oin, move_ready, illegal, x_win, o_win, draw, ai_fault, game_over};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] vec(input logic [8:0] x, input logic [8:0] o, input logic [6:0] f);
    return {x, o, f};
  endfunction

  task automatic push(input int c, input logic [24:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [24:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end else begin
      $display("check %s ok state=%h", name, act);
    end
  endtask

  // Monitor: pops and compares on every output event.
  initial begin
    logic prev_ready;
    logic prev_over;
    exp_t e;
    prev_ready = 1'b1;
    prev_over  = 1'b0;
    forever begin
      @(negedge clk);
      if ((move_ready && !prev_ready) || illegal || (game_over && !prev_over)) begin
        txn++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event txn=%0d got=%h want=none", txn, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL txn%0d got=%h at cyc %0d want=%h at cyc %0d", txn, act, cyc, e.v, e.cyc);
          end else begin
            $display("txn %0d ok xin=%h oin=%h flags=%b cyc=%0d", txn, xin, oin, act[6:0], cyc);
          end
        end
      end
      prev_ready = move_ready;
      prev_over  = game_over;
    end
  end

  // One X move with a preset AI answer; expected outcome after lat cycles.
  task automatic do_move(input logic [3:0] pos, input logic [8:0] ai, input int lat,
                         input logic [8:0] ex, input logic [8:0] eo, input logic [6:0] fl,
                         input bit hold);
    @(negedge clk);
    ai_move    = ai;
    move_valid = 1'b1;
    move_pos   = pos;
    push(cyc + lat, vec(ex, eo, fl));
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      // Present a move while busy; it must be ignored, not queued.
      move_pos = 4'd8;
      @(negedge clk);
      @(negedge clk);
    end
    move_valid = 1'b0;
    for (int i = 0; i < 12 && !(move_ready || game_over); i++) @(negedge clk);
    if (!(move_ready || game_over)) begin
      checks++;
      errors++;
      $display("FAIL move_timeout got=%h want=ready_or_over", act);
    end
    @(negedge clk);
  endtask

  // new_game pulse, optionally with a simultaneous move request.
  task automatic ng(input bit with_move, input bit expect_event);
    @(negedge clk);
    new_game   = 1'b1;
    move_valid = with_move;
    move_pos   = 4'd4;
    if (expect_event) push(cyc + 1, vec(9'h000, 9'h000, F_RDY));
    @(posedge clk);
    @(negedge clk);
    new_game   = 1'b0;
    move_valid = 1'b0;
    chk("new_game_clear", vec(9'h000, 9'h000, F_RDY));
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset", vec(9'h000, 9'h000, F_RDY));
    @(negedge clk);
    rst_n = 1'b1;

    // Game 1: O wins on the middle row; illegal moves interleaved.
    do_move(4'd8,  9'h010, 4, 9'h001, 9'h010, F_RDY, 1'b0);
    do_move(4'd4,  9'h010, 1, 9'h001, 9'h010, F_ILL, 1'b0);
    do_move(4'd12, 9'h010, 1, 9'h001, 9'h010, F_ILL, 1'b0);
    do_move(4'd0,  9'h020, 4, 9'h101, 9'h030, F_RDY, 1'b0);
    do_move(4'd2,  9'h008, 4, 9'h141, 9'h038, F_OW,  1'b0);
    ng(1'b1, 1'b1);
    ng(1'b1, 1'b0);

    // X wins on the top row; the middle move also tests busy-time requests.
    do_move(4'd0, 9'h020, 4, 9'h100, 9'h020, F_RDY, 1'b0);
    do_move(4'd1, 9'h010, 4, 9'h180, 9'h030, F_RDY, 1'b1);
    do_move(4'd2, 9'h001, 2, 9'h1C0, 9'h030, F_XW,  1'b0);
    ng(1'b0, 1'b1);

    // AI faults: two bits, no bits, overlap with X.
    do_move(4'd0, 9'h003, 3, 9'h100, 9'h000, F_AF, 1'b0);
    ng(1'b0, 1'b1);
    do_move(4'd0, 9'h000, 3, 9'h100, 9'h000, F_AF, 1'b0);
    ng(1'b0, 1'b1);
    do_move(4'd0, 9'h100, 3, 9'h100, 9'h000, F_AF, 1'b0);
    ng(1'b0, 1'b1);

    // Draw on the final X move.
    do_move(4'd0, 9'h010, 4, 9'h100, 9'h010, F_RDY, 1'b0);
    do_move(4'd8, 9'h080, 4, 9'h101, 9'h090, F_RDY, 1'b0);
    do_move(4'd7, 9'h004, 4, 9'h103, 9'h094, F_RDY, 1'b0);
    do_move(4'd3, 9'h008, 4, 9'h123, 9'h09C, F_RDY, 1'b0);
    do_move(4'd2, 9'h001, 2, 9'h163, 9'h09C, F_DR,  1'b0);
    ng(1'b0, 1'b1);

    // Asynchronous reset while in the AI state.
    @(negedge clk);
    ai_move    = 9'h010;
    move_valid = 1'b1;
    move_pos   = 4'd0;
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ai_state", vec(9'h100, 9'h000, F_BUSY));
    #1;
    push(-1, vec(9'h000, 9'h000, F_RDY));
    rst_n = 1'b0;
    #1;
    chk("async_reset", vec(9'h000, 9'h000, F_RDY));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_move(4'd4, 9'h100, 4, 9'h010, 9'h100, F_RDY, 1'b0);

`ifdef TTT_SCORE_EN
    ng(1'b0, 1'b0);
    for (int g = 0; g < 16; g++) begin
      do_move(4'd0, 9'h020, 4, 9'h100, 9'h020, F_RDY, 1'b0);
      do_move(4'd1, 9'h010, 4, 9'h180, 9'h030, F_RDY, 1'b0);
      do_move(4'd8, 9'h008, 4, 9'h181, 9'h038, F_OW,  1'b0);
      checks++;
      if (o_score !== ((g < 15) ? 4'(g + 1) : 4'd15) || x_score !== 4'd0 || draw_score !== 4'd0) begin
        errors++;
        $display("FAIL score game %0d got o=%0d x=%0d d=%0d want o=%0d x=0 d=0",
                 g, o_score, x_score, draw_score, (g < 15) ? g + 1 : 15);
      end else begin
        $display("check score game %0d ok o=%0d", g, o_score);
      end
      ng(1'b0, 1'b1);
    end
`endif

    // Drain remaining expectations with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks += exp_q.size();
      errors += exp_q.size();
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
